// File: rtl/spmv_pkg.sv
// Shared AXI constants and the Val fetch FSM state type.
package spmv_pkg;
    localparam int         AXI_ADDR_W     = 48;
    localparam int         AXI_DATA_W     = 256;
    localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        DRAIN,
        DONE,
        ERRD
    } fetch_state_e;
endpackage

// File: rtl/spmv_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; push/pop 1-cycle, head visible while !empty.
// Push is dropped when full and pop ignored when empty; callers are expected to respect full/empty.
module spmv_sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat_i;
    end

    assign pop_dat_o = mem_q[rd_q];
    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign count_o   = cnt_q;
endmodule

// File: rtl/spmv_val_fetch.sv
// AXI4 read master streaming one SpMV job's Val beats from HBM to the multiply datapath (FWFT, 1-cycle R-to-FIFO).
// Bursts reserve FIFO credit before AR is raised, so rready stays high while busy and tready stalls only block new ARs.
module spmv_val_fetch
    import spmv_pkg::*;
#(
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [AXI_ADDR_W-1:0]   cfg_base_addr,
    input  logic [31:0]             cfg_num_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [AXI_ADDR_W-1:0]   m_axi_Val_araddr,
    output logic [7:0]              m_axi_Val_arlen,
    output logic [2:0]              m_axi_Val_arsize,
    output logic [1:0]              m_axi_Val_arburst,
    output logic                    m_axi_Val_arvalid,
    input  logic                    m_axi_Val_arready,
    input  logic [AXI_DATA_W-1:0]   m_axi_Val_rdata,
    input  logic [1:0]              m_axi_Val_rresp,
    input  logic                    m_axi_Val_rlast,
    input  logic                    m_axi_Val_rvalid,
    output logic                    m_axi_Val_rready,
    output logic [AXI_ADDR_W-1:0]   m_axi_Val_awaddr,
    output logic [7:0]              m_axi_Val_awlen,
    output logic [2:0]              m_axi_Val_awsize,
    output logic [1:0]              m_axi_Val_awburst,
    output logic                    m_axi_Val_awvalid,
    input  logic                    m_axi_Val_awready,
    output logic [AXI_DATA_W-1:0]   m_axi_Val_wdata,
    output logic [AXI_DATA_W/8-1:0] m_axi_Val_wstrb,
    output logic                    m_axi_Val_wlast,
    output logic                    m_axi_Val_wvalid,
    input  logic                    m_axi_Val_wready,
    input  logic                    m_axi_Val_bvalid,
    input  logic [1:0]              m_axi_Val_bresp,
    output logic                    m_axi_Val_bready,
    output logic [AXI_DATA_W-1:0]   m_axis_val_tdata,
    output logic                    m_axis_val_tvalid,
    input  logic                    m_axis_val_tready,
    output logic                    m_axis_val_tlast
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int OST_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int ALIGN_W = $clog2(BURST_LEN * 32);

    fetch_state_e          state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           nbeats_q, nbeats_d;
    logic [31:0]           rem_q, rem_d;
    logic [31:0]           inflight_q, inflight_d;
    logic [31:0]           rbeat_q, rbeat_d;
    logic [31:0]           out_cnt_q, out_cnt_d;
    logic [OST_W-1:0]      outst_q, outst_d;
    logic                  mis_q, mis_d;
    logic                  err_q, err_d;
    logic                  arvalid_q, arvalid_d;

    logic [31:0]      len;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty, fifo_full_unused;
    logic             ar_raise, ar_fire, r_fire, r_end, pop;
    logic             unused_ok;

    assign len      = (rem_q >= 32'(BURST_LEN)) ? 32'(BURST_LEN) : rem_q;
    // Credit and outstanding slots are claimed when arvalid rises, which keeps AR fields frozen until arready.
    assign ar_raise = (state_q == RUN) && !arvalid_q && (rem_q != 32'd0)
                   && (outst_q < OST_W'(MAX_OUTSTANDING))
                   && (32'(fifo_cnt) + inflight_q + len <= 32'(FIFO_DEPTH));
    assign ar_fire  = arvalid_q && m_axi_Val_arready;
    assign r_fire   = m_axi_Val_rvalid && m_axi_Val_rready;
    assign r_end    = r_fire && m_axi_Val_rlast;
    assign pop      = m_axis_val_tvalid && m_axis_val_tready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nbeats_d   = nbeats_q;
        rem_d      = rem_q;
        inflight_d = inflight_q;
        rbeat_d    = rbeat_q;
        out_cnt_d  = out_cnt_q;
        outst_d    = outst_q;
        mis_d      = mis_q;
        err_d      = err_q;
        arvalid_d  = arvalid_q;

        case (state_q)
            IDLE: if (start) begin
                state_d    = CHECK;
                addr_d     = cfg_base_addr;
                nbeats_d   = cfg_num_beats;
                rem_d      = cfg_num_beats;
                mis_d      = |cfg_base_addr[ALIGN_W-1:0];
                err_d      = 1'b0;
                inflight_d = '0;
                rbeat_d    = '0;
                out_cnt_d  = '0;
                outst_d    = '0;
            end
            CHECK: begin
                if (nbeats_q == 32'd0) begin
                    state_d = DONE;
                end else if (mis_q) begin
                    state_d = ERRD;
                    err_d   = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN:   if (rem_q == 32'd0 && !arvalid_q) state_d = DRAIN;
            DRAIN: if ((pop && m_axis_val_tlast) || out_cnt_q == nbeats_q) state_d = DONE;
            DONE:  state_d = IDLE;
            ERRD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (ar_raise) arvalid_d = 1'b1;
        if (ar_fire) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + AXI_ADDR_W'(len << 5);
            rem_d     = rem_q - len;
        end
        if (ar_raise || r_end) begin
            outst_d    = outst_q + OST_W'(ar_raise) - OST_W'(r_end);
            inflight_d = inflight_q + (ar_raise ? len : 32'd0) - (r_end ? rbeat_q + 32'd1 : 32'd0);
        end
        if (r_fire) begin
            rbeat_d = r_end ? 32'd0 : rbeat_q + 32'd1;
            if (m_axi_Val_rresp != RESP_OKAY) err_d = 1'b1;
        end
        if (pop) out_cnt_d = out_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            nbeats_q   <= '0;
            rem_q      <= '0;
            inflight_q <= '0;
            rbeat_q    <= '0;
            out_cnt_q  <= '0;
            outst_q    <= '0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nbeats_q   <= nbeats_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            rbeat_q    <= rbeat_d;
            out_cnt_q  <= out_cnt_d;
            outst_q    <= outst_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
            arvalid_q  <= arvalid_d;
        end
    end

    spmv_sync_fifo #(
        .WIDTH (AXI_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (r_fire),
        .push_dat_i (m_axi_Val_rdata),
        .pop_i      (pop),
        .pop_dat_o  (m_axis_val_tdata),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full_unused),
        .count_o    (fifo_cnt)
    );

    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE) || (state_q == ERRD);
    assign err               = err_q;
    assign m_axi_Val_araddr  = addr_q;
    assign m_axi_Val_arlen   = 8'(len - 32'd1);
    assign m_axi_Val_arsize  = AXI_SIZE_32B;
    assign m_axi_Val_arburst = AXI_BURST_INCR;
    assign m_axi_Val_arvalid = arvalid_q;
    assign m_axi_Val_rready  = busy;
    assign m_axis_val_tvalid = !fifo_empty;
    assign m_axis_val_tlast  = m_axis_val_tvalid && (out_cnt_q == nbeats_q - 32'd1);

    assign m_axi_Val_awaddr  = '0;
    assign m_axi_Val_awlen   = '0;
    assign m_axi_Val_awsize  = '0;
    assign m_axi_Val_awburst = '0;
    assign m_axi_Val_awvalid = 1'b0;
    assign m_axi_Val_wdata   = '0;
    assign m_axi_Val_wstrb   = '0;
    assign m_axi_Val_wlast   = 1'b0;
    assign m_axi_Val_wvalid  = 1'b0;
    assign m_axi_Val_bready  = 1'b1;
    assign unused_ok = &{1'b0, m_axi_Val_awready, m_axi_Val_wready, m_axi_Val_bvalid,
                         m_axi_Val_bresp, fifo_full_unused};
endmodule

// File: tb/tb_spmv_val_fetch.sv
// Directed bench for spmv_val_fetch: behavioural AXI read slave, stream sink and per-job scoreboard.
module tb_spmv_val_fetch;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [47:0]  cfg_base_addr = '0;
    logic [31:0]  cfg_num_beats = '0;
    logic         busy, done, err;
    logic [47:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready = 1'b1;
    logic [255:0] rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0, rvalid = 1'b0;
    logic         rready;
    logic [47:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid, wlast, wvalid, bready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic [255:0] tdata;
    logic         tvalid, tlast;
    logic         tready = 1'b1;

    int n_pass = 0, n_chk = 0;
    int done_cnt, r_cnt, ost, max_ost, max_fifo, rb, cyc = 0;
    int r_delay = 0, slv_err_idx = -1;
    bit arv_seen, tv_seen, ar_hs, r_hs;
    logic [47:0]  ar_addr_log[$], bq_addr[$];
    logic [7:0]   ar_len_log[$], bq_len[$];
    int           bq_t[$], last_idx[$];
    logic [255:0] out_dat[$];

    spmv_val_fetch u_dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_beats(cfg_num_beats), .busy(busy), .done(done), .err(err),
        .m_axi_Val_araddr(araddr), .m_axi_Val_arlen(arlen), .m_axi_Val_arsize(arsize),
        .m_axi_Val_arburst(arburst), .m_axi_Val_arvalid(arvalid), .m_axi_Val_arready(arready),
        .m_axi_Val_rdata(rdata), .m_axi_Val_rresp(rresp), .m_axi_Val_rlast(rlast),
        .m_axi_Val_rvalid(rvalid), .m_axi_Val_rready(rready),
        .m_axi_Val_awaddr(awaddr), .m_axi_Val_awlen(awlen), .m_axi_Val_awsize(awsize),
        .m_axi_Val_awburst(awburst), .m_axi_Val_awvalid(awvalid), .m_axi_Val_awready(1'b0),
        .m_axi_Val_wdata(wdata), .m_axi_Val_wstrb(wstrb), .m_axi_Val_wlast(wlast),
        .m_axi_Val_wvalid(wvalid), .m_axi_Val_wready(1'b0), .m_axi_Val_bvalid(1'b0),
        .m_axi_Val_bresp(2'b00), .m_axi_Val_bready(bready),
        .m_axis_val_tdata(tdata), .m_axis_val_tvalid(tvalid),
        .m_axis_val_tready(tready), .m_axis_val_tlast(tlast)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] beat_dat(input logic [47:0] a);
        return {8{a[36:5]}};
    endfunction

    // Sample at the edge, then drive the slave's next R beat 1 time unit later.
    always @(posedge clk) begin
        cyc++;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (!rstn) begin
            bq_addr.delete(); bq_len.delete(); bq_t.delete();
            rb = 0; ost = 0; r_cnt = 0;
        end else begin
            if (ar_hs) begin
                ar_addr_log.push_back(araddr); ar_len_log.push_back(arlen);
                bq_addr.push_back(araddr); bq_len.push_back(arlen); bq_t.push_back(cyc);
                ost++;
            end
            if (r_hs) begin
                r_cnt++;
                if (rlast) begin
                    ost--; rb = 0;
                    void'(bq_addr.pop_front()); void'(bq_len.pop_front()); void'(bq_t.pop_front());
                end else rb++;
            end
            if (ost > max_ost) max_ost = ost;
            if (tvalid && tready) begin
                out_dat.push_back(tdata);
                if (tlast) last_idx.push_back(out_dat.size() - 1);
            end
            if (done) done_cnt++;
            if (arvalid) arv_seen = 1'b1;
            if (tvalid) tv_seen = 1'b1;
            if (int'(u_dut.u_fifo.count_o) > max_fifo) max_fifo = int'(u_dut.u_fifo.count_o);
        end
        #1;
        if (rstn && bq_addr.size() > 0 && cyc >= bq_t[0] + r_delay) begin
            rvalid = 1'b1;
            rdata  = beat_dat(bq_addr[0] + 48'(rb) * 48'd32);
            rlast  = (rb == int'(bq_len[0]));
            rresp  = (r_cnt == slv_err_idx) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic kick(input logic [47:0] base, input logic [31:0] n);
        ar_addr_log.delete(); ar_len_log.delete(); out_dat.delete(); last_idx.delete();
        done_cnt = 0; r_cnt = 0; max_ost = 0; max_fifo = 0; arv_seen = 1'b0; tv_seen = 1'b0;
        @(negedge clk);
        cfg_base_addr = base; cfg_num_beats = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_finished"}, 256'(done_cnt != 0), 256'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_job(input string tag, input logic [47:0] base, input int n);
        int bad = 0;
        chk({tag, "_beats"}, out_dat.size(), n);
        for (int k = 0; k < out_dat.size() && k < n; k++)
            if (out_dat[k] !== beat_dat(base + 48'(k) * 48'd32)) bad++;
        chk({tag, "_data_bad"}, bad, 0);
        chk({tag, "_tlast_cnt"}, last_idx.size(), 1);
        chk({tag, "_tlast_pos"}, (last_idx.size() > 0) ? last_idx[0] : -1, n - 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [47:0] e_addr [3];
        logic [7:0]  e_len  [3];
        e_addr = '{48'h1000, 48'h1200, 48'h1400};
        e_len  = '{8'd15, 8'd15, 8'd7};

        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, done, err, arvalid, tvalid, tlast, rready}, 7'b0);
        rstn = 1'b1;
        @(negedge clk);
        chk("tieoff", {awvalid, wvalid, bready, |awaddr, |awlen, |awsize, |awburst, |wdata, |wstrb, wlast}, 10'b0010000000);
        chk("ar_const", {arsize, arburst}, 5'b101_01);

        // T1: basic 40-beat job, everything ready
        kick(48'h1000, 40);
        chk("t1_busy", busy, 1);
        wait_done("t1", 2000);
        chk("t1_ar_n", ar_addr_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_araddr%0d", i), (i < ar_addr_log.size()) ? ar_addr_log[i] : '1, e_addr[i]);
            chk($sformatf("t1_arlen%0d", i), (i < ar_len_log.size()) ? ar_len_log[i] : '1, e_len[i]);
        end
        check_job("t1", 48'h1000, 40);
        chk("t1_err", err, 0);

        // T2: empty job
        kick(48'h7000, 0);
        chk("t2_done_early", done, 0);
        @(negedge clk);
        chk("t2_done", done, 1);
        @(negedge clk);
        chk("t2_idle", {busy, done}, 2'b00);
        chk("t2_no_ar", arv_seen, 0);
        chk("t2_no_tvalid", tv_seen, 0);

        // T3: stream stalled, credit must cap reservations at one FIFO's worth
        tready = 1'b0;
        kick(48'h2000, 256);
        repeat (200) @(negedge clk);
        chk("t3_ar_stall", ar_addr_log.size(), 4);
        chk("t3_r_beats", r_cnt, 64);
        chk("t3_fifo_full", u_dut.u_fifo.count_o, 64);
        chk("t3_fifo_max_ok", 256'(max_fifo <= 64), 256'(1));
        chk("t3_head_held", {tvalid, tdata}, {1'b1, beat_dat(48'h2000)});
        tready = 1'b1;
        wait_done("t3", 3000);
        chk("t3_ar_total", ar_addr_log.size(), 16);
        check_job("t3", 48'h2000, 256);
        chk("t3_err", err, 0);

        // T4: slow slave, outstanding bound
        r_delay = 50;
        kick(48'h4000, 160);
        wait_done("t4", 3000);
        chk("t4_max_ost", max_ost, 4);
        check_job("t4", 48'h4000, 160);
        r_delay = 0;

        // T5: misaligned base, then recovery
        kick(48'h1010, 40);
        wait_done("t5", 100);
        chk("t5_err", err, 1);
        chk("t5_no_ar", arv_seen, 0);
        chk("t5_done_cnt", done_cnt, 1);
        kick(48'h3000, 8);
        chk("t5_err_clr", err, 0);
        wait_done("t5b", 500);
        check_job("t5b", 48'h3000, 8);

        // T6: SLVERR on beat 5, then reset mid-job
        slv_err_idx = 5;
        kick(48'h5000, 40);
        wait_done("t6", 2000);
        chk("t6_err", err, 1);
        check_job("t6", 48'h5000, 40);
        slv_err_idx = -1;

        tready = 1'b0;
        kick(48'h6000, 256);
        repeat (40) @(negedge clk);
        chk("t6_busy_pre", {busy, tvalid}, 2'b11);
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_rst_outs", {busy, done, err, arvalid, tvalid, tlast, rready}, 7'b0);
        chk("t6_rst_fifo", u_dut.u_fifo.count_o, 0);
        rstn = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        kick(48'h8000, 24);
        wait_done("t6b", 1000);
        check_job("t6b", 48'h8000, 24);
        chk("t6b_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
